// File: rtl/tdc_arb_pkg.sv
// Shared types and constants for the TDC readout arbiter.
// The optional delivered-event counter is enabled by defining TDC_ARB_EVENT_CNT_EN.
package tdc_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_CLEAR   = 2'd2
    } arb_state_t;

    localparam int TDC_DATA_W = 32;
    localparam int EVT_CNT_W  = 16;

endpackage

// File: rtl/tdc_rr_picker.sv
// Combinational round-robin search: first requesting channel after 'last',
// wrapping back to channel 0.
module tdc_rr_picker #(
    parameter int N_CH = 4,
    parameter int ID_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [ID_W-1:0] last,
    output logic            found,
    output logic [ID_W-1:0] grant
);

    logic            hi_found;
    logic [ID_W-1:0] hi_grant;
    logic            lo_found;
    logic [ID_W-1:0] lo_grant;

    // Descending scan so the lowest matching index is the final assignment.
    // 'hi' covers channels above last; 'lo' is the wrap-around candidate.
    always_comb begin
        hi_found = 1'b0;
        hi_grant = '0;
        lo_found = 1'b0;
        lo_grant = '0;
        for (int c = N_CH - 1; c >= 0; c--) begin
            if (req[c]) begin
                lo_found = 1'b1;
                lo_grant = ID_W'(c);
                if (ID_W'(c) > last) begin
                    hi_found = 1'b1;
                    hi_grant = ID_W'(c);
                end
            end
        end
    end

    assign found = hi_found | lo_found;
    assign grant = hi_found ? hi_grant : lo_grant;

endmodule

// File: rtl/tdc_readout_arbiter.sv
// Round-robin readout controller for an array of TDC channels.
// Optional delivered-event counter: define TDC_ARB_EVENT_CNT_EN.
module tdc_readout_arbiter
    import tdc_arb_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = TDC_DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_CH-1:0]          i_cfg_enable,
    output logic [N_CH-1:0]          o_enable_channel,
    input  logic [N_CH-1:0]          i_hasEvent,
    input  logic [N_CH*DATA_W-1:0]   i_timestamp,
    input  logic [N_CH*DATA_W-1:0]   i_pulseWidth,
    output logic [N_CH-1:0]          o_clear,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [$clog2(N_CH)-1:0]  o_channel_id,
    output logic [DATA_W-1:0]        o_timestamp,
    output logic [DATA_W-1:0]        o_pulseWidth,
    output logic                     o_idle,
    output logic [EVT_CNT_W-1:0]     o_event_count
);

    localparam int ID_W = $clog2(N_CH);

    arb_state_t       state_q;
    logic [N_CH-1:0]  en_q;
    logic             valid_q;
    logic [N_CH-1:0]  clear_q;
    logic [ID_W-1:0]  id_q;
    logic [DATA_W-1:0] ts_q;
    logic [DATA_W-1:0] tot_q;
    logic [ID_W-1:0]  last_q;

    logic [N_CH-1:0]  eligible;
    logic             pick_found;
    logic [ID_W-1:0]  pick_grant;
    logic [DATA_W-1:0] win_ts;
    logic [DATA_W-1:0] win_tot;
    logic [N_CH-1:0]  clear_onehot;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q <= '0;
        end else begin
            en_q <= i_cfg_enable;
        end
    end

    // Only channels we have actually enabled may compete for the grant.
    assign eligible = i_hasEvent & en_q;

    tdc_rr_picker #(
        .N_CH (N_CH),
        .ID_W (ID_W)
    ) u_picker (
        .req   (eligible),
        .last  (last_q),
        .found (pick_found),
        .grant (pick_grant)
    );

    always_comb begin
        win_ts  = '0;
        win_tot = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (pick_grant == ID_W'(c)) begin
                win_ts  = i_timestamp[c*DATA_W +: DATA_W];
                win_tot = i_pulseWidth[c*DATA_W +: DATA_W];
            end
        end
    end

    assign clear_onehot = N_CH'(1) << last_q;

    // Valid/ready: o_valid rises with stable id/timestamp/width and stays up,
    // data frozen, until a cycle with i_ready=1; that cycle is the transfer.
    // o_valid drops on the next edge and the source channel is cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            clear_q <= '0;
            id_q    <= '0;
            ts_q    <= '0;
            tot_q   <= '0;
            last_q  <= ID_W'(N_CH - 1);
        end else begin
            clear_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_found) begin
                        state_q <= ST_PRESENT;
                        valid_q <= 1'b1;
                        id_q    <= pick_grant;
                        ts_q    <= win_ts;
                        tot_q   <= win_tot;
                        last_q  <= pick_grant;
                    end
                end
                ST_PRESENT: begin
                    if (i_ready) begin
                        state_q <= ST_CLEAR;
                        valid_q <= 1'b0;
                        clear_q <= clear_onehot;
                    end
                end
                ST_CLEAR: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_enable_channel = en_q;
    assign o_valid          = valid_q;
    assign o_clear          = clear_q;
    assign o_channel_id     = id_q;
    assign o_timestamp      = ts_q;
    assign o_pulseWidth     = tot_q;
    assign o_idle           = (state_q == ST_IDLE);

`ifdef TDC_ARB_EVENT_CNT_EN
    logic [EVT_CNT_W-1:0] cnt_q;
    logic [EVT_CNT_W-1:0] cnt_d;

    // Free-running wrap at 16 bits is intended.
    always_comb begin
        cnt_d = cnt_q;
        if (valid_q && i_ready) begin
            cnt_d = cnt_q + EVT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_event_count = cnt_q;
`else
    assign o_event_count = '0;
`endif

endmodule

// File: tb/tb_tdc_readout_arbiter.sv
// Directed bench for tdc_readout_arbiter; expected event counts follow TDC_ARB_EVENT_CNT_EN.
module tb_tdc_readout_arbiter;
  import tdc_arb_pkg::*;

  localparam int N_CH   = 4;
  localparam int DATA_W = 32;
  localparam int ID_W   = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [N_CH-1:0]        cfg_en;
  logic [N_CH-1:0]        en_ch;
  logic [N_CH-1:0]        has_ev;
  logic [N_CH*DATA_W-1:0] ts_bus;
  logic [N_CH*DATA_W-1:0] tot_bus;
  logic [N_CH-1:0]        clr;
  logic                   valid;
  logic                   ready;
  logic [ID_W-1:0]        ch_id;
  logic [DATA_W-1:0]      ts_out;
  logic [DATA_W-1:0]      tot_out;
  logic                   idle;
  logic [15:0]            evt_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [ID_W-1:0] exp_q[$];
  logic [DATA_W-1:0] ts_tab[N_CH]  = '{32'hA000_0001, 32'hB000_0022, 32'hC000_0333, 32'hD000_4444};
  logic [DATA_W-1:0] tot_tab[N_CH] = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0033, 32'h0000_0044};

  tdc_readout_arbiter #(.N_CH(N_CH), .DATA_W(DATA_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .i_cfg_enable     (cfg_en),
    .o_enable_channel (en_ch),
    .i_hasEvent       (has_ev),
    .i_timestamp      (ts_bus),
    .i_pulseWidth     (tot_bus),
    .o_clear          (clr),
    .o_valid          (valid),
    .i_ready          (ready),
    .o_channel_id     (ch_id),
    .o_timestamp      (ts_out),
    .o_pulseWidth     (tot_out),
    .o_idle           (idle),
    .o_event_count    (evt_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_event(input int ch, input logic [DATA_W-1:0] ts, input logic [DATA_W-1:0] tot);
    has_ev[ch] = 1'b1;
    ts_bus[ch*DATA_W +: DATA_W]  = ts;
    tot_bus[ch*DATA_W +: DATA_W] = tot;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    cfg_en = '0;
    has_ev = '0;
    ready  = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_valid(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      tick();
      if (valid) seen = 1'b1;
    end
    check_eq(tag, seen, 1);
  endtask

  // scoreboard: ready held high, every accepted record popped from exp_q,
  // and the one-hot clear that follows checked and applied to has_ev.
  task automatic run_events(input int budget, input bit check_spacing);
    int              last_hs;
    bit              clear_due;
    logic [ID_W-1:0] cur;
    logic [N_CH-1:0] one;
    last_hs   = -1;
    clear_due = 1'b0;
    cur       = '0;
    one       = 1;
    ready     = 1'b1;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (clear_due) begin
        check_eq("clear_onehot", clr, one << cur);
        has_ev    = has_ev & ~clr;
        clear_due = 1'b0;
      end else if (clr != '0) begin
        check_eq("spurious_clear", clr, 0);
      end
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_event_id", ch_id, 64'hFFFF);
        end else begin
          cur = exp_q.pop_front();
          check_eq("event_id", ch_id, cur);
          check_eq("event_ts", ts_out, ts_tab[cur]);
          check_eq("event_tot", tot_out, tot_tab[cur]);
          if (check_spacing && last_hs >= 0) check_eq("rr_spacing", k - last_hs, 3);
          last_hs   = k;
          clear_due = 1'b1;
        end
      end
    end
    check_eq("events_left", exp_q.size(), 0);
  endtask

  initial begin
    reset   = 1'b1;
    cfg_en  = '0;
    has_ev  = '0;
    ts_bus  = '0;
    tot_bus = '0;
    ready   = 1'b0;

    // reset state
    repeat (2) tick();
    check_eq("rst_valid", valid, 0);
    check_eq("rst_clear", clr, 0);
    check_eq("rst_enable", en_ch, 0);
    check_eq("rst_count", evt_cnt, 0);
    reset = 1'b0;
    tick();
    check_eq("post_rst_idle", idle, 1);
    check_eq("post_rst_id", ch_id, 0);
    check_eq("post_rst_ts", ts_out, 0);

    // single event on channel 0
    cfg_en = 4'b0001;
    tick();
    check_eq("single_enable", en_ch, 4'b0001);
    set_event(0, 32'h0000_1234, 32'h0000_0050);
    ready = 1'b1;
    tick();
    check_eq("single_valid", valid, 1);
    check_eq("single_id", ch_id, 0);
    check_eq("single_ts", ts_out, 32'h0000_1234);
    check_eq("single_tot", tot_out, 32'h0000_0050);
    check_eq("single_no_clear_yet", clr, 0);
    tick();
    check_eq("single_valid_drop", valid, 0);
    check_eq("single_clear", clr, 4'b0001);
    has_ev[0] = 1'b0;
    tick();
    check_eq("single_clear_gone", clr, 0);
    check_eq("single_idle", idle, 1);
    check_eq("single_ts_held", ts_out, 32'h0000_1234);

    // reset while presenting channel 1; priority restarts at channel 0
    cfg_en = 4'b1111;
    ready  = 1'b0;
    set_event(1, ts_tab[1], tot_tab[1]);
    wait_valid("mid_valid_seen");
    check_eq("mid_id", ch_id, 1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_valid", valid, 0);
    check_eq("mid_rst_clear", clr, 0);
    check_eq("mid_rst_enable", en_ch, 0);
    check_eq("mid_rst_count", evt_cnt, 0);
    check_eq("mid_rst_idle", idle, 1);
    tick();
    check_eq("mid_rst_no_clear", clr, 0);
    set_event(0, ts_tab[0], tot_tab[0]);
    set_event(2, ts_tab[2], tot_tab[2]);
    reset = 1'b0;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    run_events(30, 1'b0);

    // round-robin over all four channels
    do_reset();
    cfg_en = 4'b1111;
    for (int c = 0; c < N_CH; c++) begin
      set_event(c, ts_tab[c], tot_tab[c]);
      exp_q.push_back(ID_W'(c));
    end
    run_events(30, 1'b1);

    // backpressure on channel 1
    ready = 1'b0;
    set_event(1, ts_tab[1], tot_tab[1]);
    wait_valid("bp_valid_seen");
    for (int k = 0; k < 10; k++) begin
      check_eq("bp_valid_held", valid, 1);
      check_eq("bp_id_held", ch_id, 1);
      check_eq("bp_ts_held", ts_out, ts_tab[1]);
      check_eq("bp_tot_held", tot_out, tot_tab[1]);
      check_eq("bp_no_clear", clr, 0);
      tick();
    end
    ready = 1'b1;
    tick();
    check_eq("bp_clear", clr, 4'b0010);
    check_eq("bp_valid_drop", valid, 0);
    has_ev[1] = 1'b0;
    tick();
    check_eq("bp_clear_gone", clr, 0);

    // channel 1 disabled: only channel 3 may be served
    cfg_en = 4'b1101;
    tick();
    check_eq("dis_enable", en_ch, 4'b1101);
    set_event(1, ts_tab[1], tot_tab[1]);
    set_event(3, ts_tab[3], tot_tab[3]);
    exp_q.push_back(2'd3);
    run_events(20, 1'b0);
    check_eq("dis_ch1_pending", has_ev[1], 1);
    check_eq("dis_no_valid", valid, 0);
    check_eq("dis_idle", idle, 1);

    // delivered events since the last reset: 4 + 1 + 1
`ifdef TDC_ARB_EVENT_CNT_EN
    check_eq("event_count", evt_cnt, 6);
`else
    check_eq("event_count", evt_cnt, 0);
`endif

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
